// File: rtl/pcie_lane_channel.sv
// One direction of a PCIe link for the test harness: per-lane skew, polarity inversion,
// lane reversal and periodic error injection between a LinkOut bundle and a LinkIn bundle.
module pcie_lane_channel #(
  parameter int NUMLANES = 16,
  parameter int MAXSKEW  = 7,
  parameter int SKEWW    = 3,
  parameter int CNTW     = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUMLANES*10-1:0]    LinkIn,
  input  logic [NUMLANES-1:0]       ElecIdleIn,
  output logic [NUMLANES*10-1:0]    LinkOut,
  output logic [NUMLANES-1:0]       ElecIdleOut,
  input  logic [NUMLANES*SKEWW-1:0] LaneSkew,
  input  logic [NUMLANES-1:0]       InvertPolarity,
  input  logic                      LaneReverse,
  input  logic                      ErrInjEn,
  input  logic [CNTW-1:0]           ErrInjInterval,
  input  logic [3:0]                ErrInjLane,
  input  logic [9:0]                ErrInjMask,
  input  logic                      ErrCntClr,
  output logic [CNTW-1:0]           ErrInjCount
);

  // Clamp is done one bit wider so the comparison stays meaningful when 2**SKEWW-1 == MAXSKEW.
  localparam logic [SKEWW:0] MAXSKEW_W = (SKEWW+1)'(MAXSKEW);

  logic [CNTW-1:0]          r_int_cnt;
  logic [CNTW-1:0]          r_err_cnt;
  logic [9:0]               r_dly_sym  [NUMLANES][MAXSKEW];
  logic                     r_dly_idle [NUMLANES][MAXSKEW];
  logic [NUMLANES*10-1:0]   r_link_out;
  logic [NUMLANES-1:0]      r_idle_out;

  logic                     w_cnt_run;
  logic                     w_hit;
  logic                     w_lane_ok;
  logic                     w_inject;
  logic [15:0]              w_idle_pad;
  logic [9:0]               w_tap0_sym [NUMLANES];
  logic [SKEWW-1:0]         w_skew     [NUMLANES];
  logic [9:0]               w_sel_sym  [NUMLANES];
  logic                     w_sel_idle [NUMLANES];
  logic [9:0]               w_proc_sym [NUMLANES];
  logic [NUMLANES-1:0]      w_proc_idle;
  logic [NUMLANES*10-1:0]   w_rev_sym;
  logic [NUMLANES-1:0]      w_rev_idle;

  always_comb begin
    w_idle_pad = '0;
    w_idle_pad[NUMLANES-1:0] = ElecIdleIn;
  end

  assign w_cnt_run = ErrInjEn && (ErrInjInterval != '0);
  assign w_hit     = w_cnt_run && (r_int_cnt == (ErrInjInterval - CNTW'(1)));
  assign w_lane_ok = ({1'b0, ErrInjLane} < 5'(NUMLANES));
  assign w_inject  = w_hit && w_lane_ok && (ErrInjMask != '0) && !w_idle_pad[ErrInjLane];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_int_cnt <= '0;
    end else if (!w_cnt_run || w_hit) begin
      r_int_cnt <= '0;
    end else begin
      r_int_cnt <= r_int_cnt + CNTW'(1);
    end
  end

  // Clear has priority over a coincident injection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_err_cnt <= '0;
    end else if (ErrCntClr) begin
      r_err_cnt <= '0;
    end else if (w_inject && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + CNTW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUMLANES; i++) begin
      w_tap0_sym[i] = LinkIn[i*10 +: 10];
      if (w_inject && (ErrInjLane == 4'(i))) begin
        w_tap0_sym[i] = LinkIn[i*10 +: 10] ^ ErrInjMask;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUMLANES; i++) begin
        for (int k = 0; k < MAXSKEW; k++) begin
          r_dly_sym[i][k]  <= '0;
          r_dly_idle[i][k] <= 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUMLANES; i++) begin
        r_dly_sym[i][0]  <= w_tap0_sym[i];
        r_dly_idle[i][0] <= ElecIdleIn[i];
        for (int k = 1; k < MAXSKEW; k++) begin
          r_dly_sym[i][k]  <= r_dly_sym[i][k-1];
          r_dly_idle[i][k] <= r_dly_idle[i][k-1];
        end
      end
    end
  end

  // Tap k lives in delay entry k-1; tap 0 bypasses the line.
  always_comb begin
    for (int i = 0; i < NUMLANES; i++) begin
      w_skew[i] = LaneSkew[i*SKEWW +: SKEWW];
      if ({1'b0, LaneSkew[i*SKEWW +: SKEWW]} > MAXSKEW_W) begin
        w_skew[i] = SKEWW'(MAXSKEW);
      end
      w_sel_sym[i]  = w_tap0_sym[i];
      w_sel_idle[i] = ElecIdleIn[i];
      for (int k = 1; k <= MAXSKEW; k++) begin
        if (w_skew[i] == SKEWW'(k)) begin
          w_sel_sym[i]  = r_dly_sym[i][k-1];
          w_sel_idle[i] = r_dly_idle[i][k-1];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUMLANES; i++) begin
      w_proc_idle[i] = w_sel_idle[i];
      if (w_sel_idle[i]) begin
        w_proc_sym[i] = 10'h000;
      end else if (InvertPolarity[i]) begin
        w_proc_sym[i] = ~w_sel_sym[i];
      end else begin
        w_proc_sym[i] = w_sel_sym[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUMLANES; j++) begin
      if (LaneReverse) begin
        w_rev_sym[j*10 +: 10] = w_proc_sym[NUMLANES-1-j];
        w_rev_idle[j]         = w_proc_idle[NUMLANES-1-j];
      end else begin
        w_rev_sym[j*10 +: 10] = w_proc_sym[j];
        w_rev_idle[j]         = w_proc_idle[j];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_link_out <= '0;
      r_idle_out <= '1;
    end else begin
      r_link_out <= w_rev_sym;
      r_idle_out <= w_rev_idle;
    end
  end

  assign LinkOut     = r_link_out;
  assign ElecIdleOut = r_idle_out;
  assign ErrInjCount = r_err_cnt;

endmodule

// File: tb/tb_pcie_lane_channel.sv
// Directed bench for pcie_lane_channel: a default 16-lane instance plus a 4-lane
// instance with wide skew fields (clamp) and a short counter (saturation).
module tb_pcie_lane_channel;

  logic         Clk;
  logic         Reset;

  logic [159:0] a_link_in;
  logic [15:0]  a_idle_in;
  logic [159:0] a_link_out;
  logic [15:0]  a_idle_out;
  logic [47:0]  a_skew;
  logic [15:0]  a_inv;
  logic         a_rev;
  logic         a_en;
  logic [15:0]  a_int;
  logic [3:0]   a_lane;
  logic [9:0]   a_mask;
  logic         a_clr;
  logic [15:0]  a_cnt;

  logic [39:0]  b_link_in;
  logic [3:0]   b_idle_in;
  logic [39:0]  b_link_out;
  logic [3:0]   b_idle_out;
  logic [15:0]  b_skew;
  logic [3:0]   b_inv;
  logic         b_rev;
  logic         b_en;
  logic [2:0]   b_int;
  logic [3:0]   b_lane;
  logic [9:0]   b_mask;
  logic         b_clr;
  logic [2:0]   b_cnt;

  int n_checks = 0;
  int n_err    = 0;

  pcie_lane_channel u_dut_a (
    .Clk(Clk), .Reset(Reset),
    .LinkIn(a_link_in), .ElecIdleIn(a_idle_in),
    .LinkOut(a_link_out), .ElecIdleOut(a_idle_out),
    .LaneSkew(a_skew), .InvertPolarity(a_inv), .LaneReverse(a_rev),
    .ErrInjEn(a_en), .ErrInjInterval(a_int), .ErrInjLane(a_lane),
    .ErrInjMask(a_mask), .ErrCntClr(a_clr), .ErrInjCount(a_cnt)
  );

  pcie_lane_channel #(.NUMLANES(4), .MAXSKEW(7), .SKEWW(4), .CNTW(3)) u_dut_b (
    .Clk(Clk), .Reset(Reset),
    .LinkIn(b_link_in), .ElecIdleIn(b_idle_in),
    .LinkOut(b_link_out), .ElecIdleOut(b_idle_out),
    .LaneSkew(b_skew), .InvertPolarity(b_inv), .LaneReverse(b_rev),
    .ErrInjEn(b_en), .ErrInjInterval(b_int), .ErrInjLane(b_lane),
    .ErrInjMask(b_mask), .ErrCntClr(b_clr), .ErrInjCount(b_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat [4];
    lat = '{1, 4, 8, 8};

    Reset     = 1'b1;
    a_link_in = '0; a_idle_in = '0; a_skew = '0; a_inv = '0; a_rev = 1'b0;
    a_en = 1'b0; a_int = '0; a_lane = '0; a_mask = '0; a_clr = 1'b0;
    b_link_in = '0; b_idle_in = '0; b_inv = '0; b_rev = 1'b0;
    b_skew = 16'h9730;
    b_en = 1'b0; b_int = '0; b_lane = '0; b_mask = '0; b_clr = 1'b0;

    // Reset values, before and after clock edges
    #2;
    check("rst_link_a", 32'(a_link_out[9:0]), 32'h0);
    check("rst_idle_a", 32'(a_idle_out), 32'hFFFF);
    check("rst_cnt_a", 32'(a_cnt), 32'h0);
    tick(); tick();
    check("rst_idle_a_clk", 32'(a_idle_out), 32'hFFFF);
    check("rst_idle_b_clk", 32'(b_idle_out), 32'hF);

    // Test 1: latency 1 at skew 0
    Reset = 1'b0;
    a_link_in[9:0] = 10'h17C;
    #2;
    check("t1_no_comb_path", 32'(a_link_out[9:0]), 32'h0);
    tick();
    check("t1_lane0", 32'(a_link_out[9:0]), 32'h17C);
    check("t1_idle", 32'(a_idle_out), 32'h0);
    a_link_in[9:0] = 10'h000;
    tick();
    check("t1_lane0_next", 32'(a_link_out[9:0]), 32'h0);

    // Test 2: skews 0,3,7,9(clamped) on the 4-lane instance
    for (int i = 0; i < 8; i++) tick();
    b_link_in = {4{10'h2AA}};
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 1) b_link_in = '0;
      for (int l = 0; l < 4; l++) begin
        check($sformatf("t2_skew_l%0d_c%0d", l, t), 32'(b_link_out[l*10 +: 10]),
              (t == lat[l]) ? 32'h2AA : 32'h0);
      end
    end
    check("t2_idle", 32'(b_idle_out), 32'h0);

    // Test 3: polarity, then idle forcing
    a_inv = 16'h0002;
    a_link_in[19:10] = 10'h0F0;
    tick();
    check("t3_inv_l1", 32'(a_link_out[19:10]), 32'h30F);
    check("t3_noinv_l0", 32'(a_link_out[9:0]), 32'h0);
    a_idle_in[1] = 1'b1;
    tick();
    check("t3_idle_sym", 32'(a_link_out[19:10]), 32'h0);
    check("t3_idle_out", 32'(a_idle_out), 32'h0002);
    a_rev = 1'b1;
    tick();
    check("t3_rev_idle", 32'(a_idle_out), 32'h4000);
    check("t3_rev_sym14", 32'(a_link_out[149:140]), 32'h0);
    a_rev = 1'b0; a_idle_in = '0; a_inv = '0; a_link_in = '0;

    // Test 4: lane reversal on 4 lanes
    b_skew = '0;
    b_rev = 1'b1;
    b_link_in = {10'h004, 10'h003, 10'h002, 10'h001};
    tick();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t4_rev_l%0d", j), 32'(b_link_out[j*10 +: 10]), 32'(4 - j));
    end
    b_rev = 1'b0;
    tick();
    check("t4_unrev_l0", 32'(b_link_out[9:0]), 32'h001);

    // Count saturation and suppression on the 3-bit counter, interval 1
    b_link_in = '0;
    b_en = 1'b1; b_int = 3'd1; b_lane = 4'd0; b_mask = 10'h3FF;
    for (int t = 1; t <= 9; t++) begin
      tick();
      check($sformatf("sat_cnt_c%0d", t), 32'(b_cnt), (t < 7) ? 32'(t) : 32'd7);
      if (t == 1) check("sat_inj_sym", 32'(b_link_out[9:0]), 32'h3FF);
    end
    b_clr = 1'b1;
    tick();
    check("sat_clr_wins", 32'(b_cnt), 32'h0);
    b_clr = 1'b0; b_lane = 4'd5;
    tick(); tick();
    check("sup_lane_range_cnt", 32'(b_cnt), 32'h0);
    check("sup_lane_range_sym", 32'(b_link_out[9:0]), 32'h0);
    b_lane = 4'd0; b_mask = 10'h000;
    tick();
    check("sup_mask0_cnt", 32'(b_cnt), 32'h0);
    b_mask = 10'h3FF; b_idle_in = 4'h1;
    tick();
    check("sup_idle_cnt", 32'(b_cnt), 32'h0);
    check("sup_idle_out", 32'(b_idle_out), 32'h1);
    b_en = 1'b0; b_idle_in = '0;

    // Test 5: interval 4 on lane 2
    a_link_in = {16{10'h100}};
    a_int = 16'd4; a_lane = 4'd2; a_mask = 10'h001; a_en = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("t5_l2_c%0d", t), 32'(a_link_out[29:20]),
            ((t % 4) == 0) ? 32'h101 : 32'h100);
      check($sformatf("t5_cnt_c%0d", t), 32'(a_cnt), 32'(t / 4));
    end
    check("t5_cnt_20", 32'(a_cnt), 32'd5);
    tick(); tick(); tick();
    check("t5_l2_c23", 32'(a_link_out[29:20]), 32'h100);
    a_clr = 1'b1;
    tick();
    check("t5_clr_cnt", 32'(a_cnt), 32'h0);
    check("t5_clr_l2", 32'(a_link_out[29:20]), 32'h101);
    a_clr = 1'b0;
    a_int = 16'd0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check($sformatf("t5_int0_l2_c%0d", t), 32'(a_link_out[29:20]), 32'h100);
    end
    check("t5_int0_cnt", 32'(a_cnt), 32'h0);

    // Test 6: reset mid-traffic with skew 5 and injection running
    a_int = 16'd4;
    a_skew = {16{3'd5}};
    a_link_in = {16{10'h155}};
    for (int t = 0; t < 10; t++) tick();
    check("t6_pre_l0", 32'(a_link_out[9:0]), 32'h155);
    check("t6_pre_cnt", 32'(a_cnt), 32'd2);
    Reset = 1'b1;
    #1;
    check("t6_async_link", 32'(a_link_out[9:0]), 32'h0);
    check("t6_async_idle", 32'(a_idle_out), 32'hFFFF);
    check("t6_async_cnt", 32'(a_cnt), 32'h0);
    tick(); tick();
    check("t6_hold_idle", 32'(a_idle_out), 32'hFFFF);
    Reset = 1'b0;
    for (int t = 1; t <= 13; t++) begin
      tick();
      check($sformatf("t6_idle_c%0d", t), 32'(a_idle_out), (t <= 5) ? 32'hFFFF : 32'h0);
      check($sformatf("t6_l0_c%0d", t), 32'(a_link_out[9:0]), (t <= 5) ? 32'h0 : 32'h155);
      check($sformatf("t6_l2_c%0d", t), 32'(a_link_out[29:20]),
            (t <= 5) ? 32'h0 : ((((t - 5) % 4) == 0) ? 32'h154 : 32'h155));
      check($sformatf("t6_cnt_c%0d", t), 32'(a_cnt), 32'(t / 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_lane_channel.md
Name: pcie_lane_channel

Overview:
- Parametrised, registered model of one direction of a PCIe link, placed between a host or endpoint LinkOut bundle and the partner's LinkIn bundle in the test harness.
- Carries NUMLANES 10-bit symbol lanes plus per-lane electrical idle.
- Adds per-lane programmable skew, polarity inversion, lane reversal and periodic error injection, so lane deskew and error recovery can be exercised without changing the VHost models.
- One instance is used per direction (down and up).

Parameters:
- NUMLANES, 16, number of lanes carried (1..16).
- MAXSKEW, 7, maximum extra per-lane delay in cycles (1..15).
- SKEWW, 3, width of each per-lane skew field; must satisfy 2**SKEWW > MAXSKEW.
- CNTW, 16, width of the error-injection interval counter and the injected-error count.

Ports:
- Clk  in  1  Symbol clock; all state is updated on the rising edge.
- Reset  in  1  Asynchronous, active-high reset.
- LinkIn  in  NUMLANES*10  Input symbols; lane i occupies bits [i*10+9:i*10].
- ElecIdleIn  in  NUMLANES  Per-lane electrical idle in.
- LinkOut  out  NUMLANES*10  Output symbols, registered.
- ElecIdleOut  out  NUMLANES  Per-lane electrical idle out, registered.
- LaneSkew  in  NUMLANES*SKEWW  Extra delay for each lane; values above MAXSKEW are clamped to MAXSKEW.
- InvertPolarity  in  NUMLANES  Per-lane bitwise inversion of the symbol.
- LaneReverse  in  1  Reverses lane order at the output.
- ErrInjEn  in  1  Enables error injection.
- ErrInjInterval  in  CNTW  Cycles between injections; 0 disables injection.
- ErrInjLane  in  4  Target input lane for injection.
- ErrInjMask  in  10  Value XORed into the target symbol on injection.
- ErrCntClr  in  1  Synchronous clear of ErrInjCount.
- ErrInjCount  out  CNTW  Number of injections performed; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high) clears all of the following:
  - LinkOut = 0 and ElecIdleOut = all-ones (link idle after reset).
  - ErrInjCount = 0 and the interval counter = 0.
  - Delay-line data = 0 and delay-line idle bits = 1.
  - Reset asserted mid-traffic discards all in-flight symbols immediately.
- Pipeline order per lane:
  1. Inject.
  2. Delay.
  3. Idle-force.
  4. Polarity.
  5. Reverse.
  6. Output register.
- Latency for lane i is 1 + min(LaneSkew[i], MAXSKEW) cycles. With skew 0 the latency is exactly 1 cycle.
  - Each lane has a delay line of MAXSKEW entries for {symbol, idle}.
  - Tap 0 is the current injected input; tap k is the value k cycles earlier.
  - The output register loads the tap selected by the clamped skew.
  - A skew change takes effect on the next edge. Symbols may then be dropped or repeated; this is not an error.
- Idle force: if the selected tap's idle bit is 1, the lane's symbol becomes 10'h000, is not inverted, and ElecIdleOut for that lane is 1.
- Polarity: if the lane is not idle and InvertPolarity[i] = 1, the symbol becomes the bitwise inverse of the delayed symbol.
- Lane reverse: when LaneReverse = 1, output lane j = processed lane (NUMLANES-1-j), for both symbol and idle.
  - Reversal is applied to the registered output path and takes effect on the next edge.
  - InvertPolarity and LaneSkew stay indexed by input lane.
- Error injection:
  - While ErrInjEn = 1 and ErrInjInterval != 0, the counter increments each cycle.
  - When the counter equals ErrInjInterval-1, input lane ErrInjLane is XORed with ErrInjMask at tap 0 and the counter returns to 0.
  - An injection is suppressed, but the counter still wraps, if ErrInjLane >= NUMLANES, ErrInjMask = 0, or ElecIdleIn[ErrInjLane] = 1.
  - ErrInjEn = 0 or ErrInjInterval = 0 holds the counter at 0 synchronously.
  - Interval 1 injects every cycle.
- ErrInjCount:
  - Increments by 1 on each performed injection and saturates at all-ones.
  - When ErrCntClr coincides with an injection, the clear wins and the result is 0.
- No handshake; the block accepts a symbol on every cycle.

Test Plan:
1. Reset, then LinkIn lane0 = 10'h17C, all skew 0, idle 0 -> LinkOut lane0 = 10'h17C exactly 1 cycle later; during reset LinkOut = 0 and ElecIdleOut = 16'hFFFF.
2. Lane skews {lane0 = 0, lane1 = 3, lane2 = 7, lane3 = 9} with a marker symbol 10'h2AA on all lanes in one cycle -> the marker appears at latencies 1, 4, 8 and 8 (lane3 clamped to MAXSKEW).
3. InvertPolarity = 16'h0002 with lane1 input 10'h0F0 -> output 10'h30F. Then ElecIdleIn[1] = 1 -> output 10'h000 and ElecIdleOut[1] = 1 after the lane latency.
4. LaneReverse = 1, NUMLANES = 4, lanes 0..3 = 10'h001..10'h004 -> LinkOut lanes 0..3 = 10'h004, 10'h003, 10'h002, 10'h001.
5. ErrInjEn = 1, interval 4, lane 2, mask 10'h001, constant input 10'h100 -> lane2 output is 10'h101 on every 4th cycle and ErrInjCount increments to 5 after 20 cycles. ErrCntClr on an injection cycle -> count 0. Interval 0 -> no injections.
6. Assert Reset mid-traffic with skew 5 and injection active -> outputs return to reset values immediately; no stale symbols appear after Reset is released; the first injection occurs ErrInjInterval cycles after release.
